// File: rtl/la_cmd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | la_cmd_pkg: encodings and field positions of the LA command protocol |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package la_cmd_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_READ  = 3'd2;
  localparam logic [2:0] OP_RUN   = 3'd3;
  localparam logic [2:0] OP_CLEAR = 3'd4;

  localparam logic [1:0] STS_OK       = 2'd0;
  localparam logic [1:0] STS_BAD_OP   = 2'd1;
  localparam logic [1:0] STS_BAD_ADDR = 2'd2;
  localparam logic [1:0] STS_BAD_ARG  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RUN  = 2'd2,
    S_RESP = 2'd3
  } state_e;

  localparam int REQ_BIT      = 31;
  localparam int OP_HI        = 26;
  localparam int OP_LO        = 24;
  localparam int ADDR_HI      = 23;
  localparam int ADDR_LO      = 20;
  localparam int WDATA_HI     = 19;
  localparam int DATA_HI      = 23;

  localparam int RSP_ACK      = 31;
  localparam int RSP_BUSY     = 30;
  localparam int RSP_STS_HI   = 29;
  localparam int RSP_STS_LO   = 28;
  localparam int RSP_OVR      = 27;
  localparam int RSP_OP_HI    = 26;
  localparam int RSP_OP_LO    = 24;
  localparam int RSP_RDATA_HI = 23;

  function automatic logic [1:0] cmd_status(input logic [2:0] op,
                                            input logic       addr_ok,
                                            input logic       arg_ok);
    logic [1:0] sts;
    sts = STS_OK;
    case (op)
      OP_NOP, OP_CLEAR: sts = STS_OK;
      OP_WRITE, OP_READ: sts = addr_ok ? STS_OK : STS_BAD_ADDR;
      OP_RUN:   sts = arg_ok ? STS_OK : STS_BAD_ARG;
      default:  sts = STS_BAD_OP;
    endcase
    return sts;
  endfunction

endpackage
`default_nettype wire

// File: rtl/la_cmd_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | la_cmd_regfile: NUM_REGS x 24-bit config registers, clear-all, reg0  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module la_cmd_regfile
  import la_cmd_pkg::*;
#(
  parameter int NUM_REGS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_we,
  input  logic [3:0]  i_waddr,
  input  logic [23:0] i_wdata,
  input  logic        i_clr,
  input  logic [3:0]  i_raddr,
  output logic [23:0] o_rdata,
  output logic [23:0] o_reg0
);

  logic [23:0] regs_q [NUM_REGS];
  logic [23:0] regs_d [NUM_REGS];

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (i_clr) begin
        regs_d[i] = '0;
      end else if (i_we && (i_waddr == 4'(i))) begin
        regs_d[i] = i_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Addresses beyond the implemented registers read as zero.
  always_comb begin
    o_rdata = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i_raddr == 4'(i)) begin
        o_rdata = regs_q[i];
      end
    end
  end

  assign o_reg0 = regs_q[0];

endmodule
`default_nettype wire

// File: rtl/la_cmd_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | la_cmd_responder: toggle-handshake command executor on the LA lines  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module la_cmd_responder
  import la_cmd_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int RUN_W    = 24
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] la1_data_in,
  input  logic [31:0] la1_oenb,
  output logic [31:0] la1_data_out,
  output logic [23:0] cfg_o,
  output logic        run_active_o
);

  state_e             state_q, state_d;
  logic [31:0]        in_q, in_d;
  logic               req_prev_q, req_prev_d;
  logic               req_seen_q, req_seen_d;
  logic [2:0]         op_q, op_d;
  logic [3:0]         addr_q, addr_d;
  logic [23:0]        data_q, data_d;
  logic [RUN_W-1:0]   cnt_q, cnt_d;
  logic               ack_q, ack_d;
  logic [1:0]         status_q, status_d;
  logic               ovr_q, ovr_d;
  logic [2:0]         lastop_q, lastop_d;
  logic [23:0]        rdata_q, rdata_d;

  logic               req_eff;
  logic               addr_ok;
  logic               arg_ok;
  logic               rf_we;
  logic               rf_clr;
  logic [23:0]        rf_rdata;
  logic               w_unused;

  assign req_eff = la1_oenb[REQ_BIT] ? req_seen_q : in_q[REQ_BIT];
  assign addr_ok = int'(addr_q) < NUM_REGS;
  assign arg_ok  = data_q[RUN_W-1:0] != '0;
  assign w_unused = ^{in_q[30:27], la1_oenb[30:0], data_q[DATA_HI:ADDR_LO]};

  la_cmd_regfile #(
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .i_we    (rf_we),
    .i_waddr (addr_q),
    .i_wdata ({4'b0, data_q[WDATA_HI:0]}),
    .i_clr   (rf_clr),
    .i_raddr (addr_q),
    .o_rdata (rf_rdata),
    .o_reg0  (cfg_o)
  );

  always_comb begin
    state_d    = state_q;
    in_d       = la1_data_in;
    req_prev_d = in_q[REQ_BIT];
    req_seen_d = req_seen_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    ack_d      = ack_q;
    status_d   = status_q;
    ovr_d      = ovr_q;
    lastop_d   = lastop_q;
    rdata_d    = rdata_q;
    rf_we      = 1'b0;
    rf_clr     = 1'b0;

    // Any request edge seen while a command is in flight is an overrun.
    if (!la1_oenb[REQ_BIT] && (state_q != S_IDLE) && (in_q[REQ_BIT] != req_prev_q)) begin
      ovr_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (req_eff != req_seen_q) begin
          op_d       = in_q[OP_HI:OP_LO];
          addr_d     = in_q[ADDR_HI:ADDR_LO];
          data_d     = in_q[DATA_HI:0];
          req_seen_d = req_eff;
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_RESP;
        case (op_q)
          OP_WRITE: rf_we = addr_ok;
          OP_CLEAR: begin
            rf_clr = 1'b1;
            ovr_d  = 1'b0;
          end
          OP_RUN: begin
            if (arg_ok) begin
              cnt_d   = data_q[RUN_W-1:0];
              state_d = S_RUN;
            end
          end
          default: ;
        endcase
      end
      S_RUN: begin
        cnt_d = cnt_q - RUN_W'(1);
        if (cnt_q == RUN_W'(1)) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        ack_d    = ~ack_q;
        status_d = cmd_status(op_q, addr_ok, arg_ok);
        lastop_d = op_q;
        if (op_q == OP_READ) begin
          rdata_d = rf_rdata;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      in_q       <= '0;
      req_prev_q <= 1'b0;
      req_seen_q <= 1'b0;
      op_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      ack_q      <= 1'b0;
      status_q   <= '0;
      ovr_q      <= 1'b0;
      lastop_q   <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      in_q       <= in_d;
      req_prev_q <= req_prev_d;
      req_seen_q <= req_seen_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      status_q   <= status_d;
      ovr_q      <= ovr_d;
      lastop_q   <= lastop_d;
      rdata_q    <= rdata_d;
    end
  end

  assign run_active_o = (state_q == S_RUN);

  always_comb begin
    la1_data_out                          = '0;
    la1_data_out[RSP_ACK]                 = ack_q;
    la1_data_out[RSP_BUSY]                = (state_q != S_IDLE);
    la1_data_out[RSP_STS_HI:RSP_STS_LO]   = status_q;
    la1_data_out[RSP_OVR]                 = ovr_q;
    la1_data_out[RSP_OP_HI:RSP_OP_LO]     = lastop_q;
    la1_data_out[RSP_RDATA_HI:0]          = rdata_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_la_cmd_responder.sv
`default_nettype none
// Scoreboard bench for la_cmd_responder: directed protocol cases plus random commands.
module tb_la_cmd_responder;

  localparam int NREGS = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] la1_data_in;
  logic [31:0] la1_oenb;
  logic [31:0] la1_data_out;
  logic [23:0] cfg_o;
  logic        run_active_o;

  la_cmd_responder #(.NUM_REGS(NREGS), .RUN_W(24)) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .la1_data_in  (la1_data_in),
    .la1_oenb     (la1_oenb),
    .la1_data_out (la1_data_out),
    .cfg_o        (cfg_o),
    .run_active_o (run_active_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  status;
    logic        ovr;
    logic [2:0]  op;
    logic [23:0] rdata;
    int          lat;
    int          run_len;
    int          issue_cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          acks = 0;
  int          run_cyc = 0;
  int          busy_bad = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic        last_ack = 1'b0;
  logic        cur_req;
  logic [23:0] m_regs [16];
  logic        m_ovr;
  logic [23:0] m_rdata;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_ovr   = 1'b0;
    m_rdata = '0;
  endtask

  // Reference behaviour of one command, taken straight from the opcode rules.
  function automatic exp_t model_exec(input logic [2:0] op, input logic [23:0] pay);
    exp_t e;
    int   a;
    a         = int'(pay[23:20]);
    e.status  = 2'd0;
    e.run_len = 0;
    case (op)
      3'd1: if (a < NREGS) m_regs[a] = {4'h0, pay[19:0]}; else e.status = 2'd2;
      3'd2: if (a < NREGS) m_rdata = m_regs[a]; else begin e.status = 2'd2; m_rdata = '0; end
      3'd3: if (pay == 24'd0) e.status = 2'd3; else e.run_len = int'(pay);
      3'd4: begin
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_ovr = 1'b0;
      end
      3'd0: ;
      default: e.status = 2'd1;
    endcase
    e.op        = op;
    e.rdata     = m_rdata;
    e.ovr       = m_ovr;
    e.lat       = e.run_len + 4;
    e.issue_cyc = 0;
    return e;
  endfunction

  // lat_override: 0 = model latency, -1 = latency not checked
  task automatic send(input logic [2:0] op, input logic [23:0] pay, input int lat_override);
    exp_t e;
    @(posedge clk);
    #1;
    e = model_exec(op, pay);
    if (lat_override != 0) e.lat = lat_override;
    e.issue_cyc = cyc;
    sb_q.push_back(e);
    cur_req     = ~cur_req;
    la1_data_in = {cur_req, 4'b0, op, pay};
  endtask

  task automatic wait_acks(input int target, input string what);
    int n;
    n = 0;
    while (acks < target && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(what, acks, target);
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [23:0] pay);
    int t;
    t = acks + 1;
    send(op, pay, 0);
    wait_acks(t, "ack_timeout");
  endtask

  always @(negedge clk) begin
    if (rst) begin
      last_ack = 1'b0;
      run_cyc  = 0;
      busy_bad = 0;
    end else begin
      if (run_active_o) begin
        run_cyc++;
        if (!la1_data_out[30]) busy_bad++;
      end
      if (la1_data_out[31] != last_ack) begin
        last_ack = la1_data_out[31];
        acks++;
        if (sb_q.size() == 0) begin
          check("unexpected_ack", sb_q.size(), 1);
        end else begin
          mon_e = sb_q.pop_front();
          check("status", la1_data_out[29:28], mon_e.status);
          check("ovr", la1_data_out[27], mon_e.ovr);
          check("last_op", la1_data_out[26:24], mon_e.op);
          check("rdata", la1_data_out[23:0], mon_e.rdata);
          check("busy_after_ack", la1_data_out[30], 1'b0);
          check("run_cycles", run_cyc, mon_e.run_len);
          check("busy_in_run", busy_bad, 0);
          check("cfg_o", cfg_o, m_regs[0]);
          if (mon_e.lat >= 0) check("ack_latency", cyc - mon_e.issue_cyc, mon_e.lat);
        end
        run_cyc  = 0;
        busy_bad = 0;
      end
    end
  end

  initial begin
    int          t;
    logic [2:0]  rop;
    logic [23:0] rpay;
    la1_data_in = '0;
    la1_oenb    = '0;
    cur_req     = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_la_out", la1_data_out, 32'h0);
    check("rst_cfg", cfg_o, 24'h0);
    check("rst_run_active", run_active_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    do_cmd(3'd1, {4'd3, 20'hABCDE});
    do_cmd(3'd2, {4'd3, 20'h0});
    do_cmd(3'd1, {4'd0, 20'h12345});
    check("cfg_after_write0", cfg_o, 24'h012345);

    do_cmd(3'd2, {4'd9, 20'h0});
    do_cmd(3'd6, 24'h123456);
    do_cmd(3'd3, 24'd0);
    do_cmd(3'd3, 24'd5);

    for (int k = 0; k < 40; k++) begin
      rop = 3'($urandom_range(0, 7));
      if (rop == 3'd3) rpay = 24'($urandom_range(0, 6));
      else rpay = {4'($urandom_range(0, 15)), 20'($urandom)};
      do_cmd(rop, rpay);
    end

    // One request toggle inside a RUN: flagged, then executed afterwards.
    t = acks + 2;
    m_ovr = 1'b1;
    send(3'd3, 24'd10, 0);
    repeat (4) @(posedge clk);
    send(3'd2, {4'd3, 20'h0}, -1);
    wait_acks(t, "single_ovr_acks");

    // Two toggles inside a RUN cancel out: only the RUN is answered.
    t = acks + 1;
    send(3'd3, 24'd10, 0);
    repeat (4) @(posedge clk);
    #1;
    cur_req = ~cur_req;
    la1_data_in[31] = cur_req;
    repeat (2) @(posedge clk);
    #1;
    cur_req = ~cur_req;
    la1_data_in[31] = cur_req;
    wait_acks(t, "double_ovr_ack");
    repeat (20) @(posedge clk);
    #1;
    check("double_ovr_no_extra", acks, t);

    do_cmd(3'd4, 24'h0);
    for (int a = 0; a < 4; a++) do_cmd(3'd2, {4'(a), 20'h0});
    check("cfg_after_clear", cfg_o, 24'h0);

    la1_oenb = 32'h8000_0000;
    t = acks;
    send(3'd1, {4'd0, 20'h5A5A5}, -1);
    repeat (12) @(posedge clk);
    #1;
    check("gated_no_ack", acks, t);
    la1_oenb = '0;
    wait_acks(t + 1, "gated_ack");
    check("cfg_after_gated", cfg_o, 24'h05A5A5);

    send(3'd3, 24'd20, 0);
    repeat (8) @(posedge clk);
    #3;
    check("run_before_rst", run_active_o, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_mid_run_active", run_active_o, 1'b0);
    check("rst_mid_run_out", la1_data_out, 32'h0);
    check("rst_mid_run_cfg", cfg_o, 24'h0);
    sb_q.delete();
    m_reset();
    cur_req     = 1'b0;
    la1_data_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_cmd(3'd0, 24'h0);
    check("sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
